// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin merge of ALU and load writebacks into an in-order register-file write queue.
//   clk, n_rst (async, active-low)
//   alu_valid/alu_addr/alu_data -> alu_ready : ALU writeback request
//   mem_valid/mem_addr/mem_data -> mem_ready : load writeback request
//   wb_stall                                 : suppress the register-file write this cycle
//   rf_we/rf_wa/rf_wd                        : register-file write port (queue head)
//   ra1/ra2 -> hz1/hz2                       : pending-write hazard flags for operand reads
//   count                                    : occupied queue entries
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     alu_valid,
  input  logic [2:0]               alu_addr,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [2:0]               mem_addr,
  input  logic [31:0]              mem_data,
  output logic                     mem_ready,
  input  logic                     wb_stall,
  output logic                     rf_we,
  output logic [2:0]               rf_wa,
  output logic [31:0]              rf_wd,
  input  logic [2:0]               ra1,
  input  logic [2:0]               ra2,
  output logic                     hz1,
  output logic                     hz2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          rr_q, rr_d;
  logic          full, empty, alu_acc, mem_acc, enq;
  logic [2:0]    enq_addr;
  logic [31:0]   enq_data;
  logic [DEPTH-1:0] m1, m2;
  // Ready is forced low during reset; the cleared count already silences the write port and hazards.
  always_comb begin
    full      = count_q == (AW+1)'(DEPTH);
    empty     = count_q == '0;
    alu_ready = n_rst && !full && (!mem_valid || !rr_q);
    mem_ready = n_rst && !full && (!alu_valid || rr_q);
    alu_acc   = alu_valid && alu_ready;
    mem_acc   = mem_valid && mem_ready;
    enq       = alu_acc || mem_acc;
    enq_addr  = alu_acc ? alu_addr : mem_addr;
    enq_data  = alu_acc ? alu_data : mem_data;
    rf_we     = !empty && !wb_stall;
    rf_wa     = empty ? '0 : addr_q[head_q];
    rf_wd     = empty ? '0 : data_q[head_q];
    head_d    = head_q + AW'(rf_we);
    tail_d    = tail_q + AW'(enq);
    count_d   = count_q + (AW+1)'(enq) - (AW+1)'(rf_we);
    rr_d      = alu_acc ? 1'b1 : mem_acc ? 1'b0 : rr_q;
    count     = count_q;
    hz1       = |m1;
    hz2       = |m2;
  end
  // An entry is occupied when its distance from the head (mod DEPTH) is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [AW-1:0] off;
    logic          occ;
    assign off   = AW'(i) - head_q;
    assign occ   = {1'b0, off} < count_q;
    assign m1[i] = occ && addr_q[i] == ra1;
    assign m2[i] = occ && addr_q[i] == ra2;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rr_q    <= rr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed check of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  logic        clk = 0, n_rst = 0;
  logic        alu_valid = 0, mem_valid = 0, wb_stall = 0;
  logic [2:0]  alu_addr = 0, mem_addr = 0, ra1 = 0, ra2 = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic        alu_ready, mem_ready, rf_we, hz1, hz2;
  logic [2:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [$clog2(DEPTH):0] count;
  int n_chk = 0, n_fail = 0;
  logic [34:0] q[$];
  bit rr = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .ra1(ra1), .ra2(ra2), .hz1(hz1), .hz2(hz2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    bit e_ar, e_mr, e_we, e_h1, e_h2, is_full, is_empty;
    @(negedge clk);
    is_full  = q.size() == DEPTH;
    is_empty = q.size() == 0;
    e_ar = n_rst && !is_full && (!mem_valid || !rr);
    e_mr = n_rst && !is_full && (!alu_valid || rr);
    e_we = !is_empty && !wb_stall;
    e_h1 = 0;
    e_h2 = 0;
    foreach (q[i]) begin
      if (q[i][34:32] == ra1) e_h1 = 1;
      if (q[i][34:32] == ra2) e_h2 = 1;
    end
    chk("alu_ready", 32'(alu_ready), 32'(e_ar));
    chk("mem_ready", 32'(mem_ready), 32'(e_mr));
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_wa", 32'(rf_wa), is_empty ? 32'd0 : 32'(q[0][34:32]));
    chk("rf_wd", rf_wd, is_empty ? 32'd0 : q[0][31:0]);
    chk("hz1", 32'(hz1), 32'(e_h1));
    chk("hz2", 32'(hz2), 32'(e_h2));
    chk("count", 32'(count), 32'(q.size()));
    @(posedge clk);
    if (n_rst) begin
      if (e_we) void'(q.pop_front());
      if (alu_valid && e_ar) begin
        q.push_back({alu_addr, alu_data});
        rr = 1;
      end else if (mem_valid && e_mr) begin
        q.push_back({mem_addr, mem_data});
        rr = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    n_rst = 0;
    q.delete();
    rr = 0;
    #1;
    step();
    n_rst = 1;
  endtask

  task automatic alu_put(input logic [2:0] a, input logic [31:0] d);
    alu_valid = 1;
    alu_addr  = a;
    alu_data  = d;
    step();
    alu_valid = 0;
  endtask

  initial begin
    step();
    do_reset();
    // single ALU write, one-cycle latency
    alu_put(3, 32'h12345678);
    #1;
    chk("pin35_we", 32'(rf_we), 32'd1);
    chk("pin35_wa", 32'(rf_wa), 32'd3);
    chk("pin35_wd", rf_wd, 32'h12345678);
    step();
    chk("pin35_we_off", 32'(rf_we), 32'd0);
    chk("pin35_cnt", 32'(count), 32'd0);
    // both requesters held high: alternating grants
    do_reset();
    alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
    mem_valid = 1; mem_addr = 2; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pin36_wa", 32'(rf_wa), (i % 2) ? 32'd2 : 32'd1);
    end
    alu_valid = 0; mem_valid = 0;
    step();
    step();
    // fill under stall
    do_reset();
    wb_stall = 1;
    for (int i = 4; i < 8; i++) alu_put(3'(i), 32'(i * 16));
    alu_valid = 1;
    ra1 = 6;
    #1;
    chk("pin37_cnt", 32'(count), 32'd4);
    chk("pin37_ardy", 32'(alu_ready), 32'd0);
    chk("pin37_hz6", 32'(hz1), 32'd1);
    ra1 = 0;
    #1;
    chk("pin37_hz0", 32'(hz1), 32'd0);
    step();
    alu_valid = 0;
    wb_stall = 0;
    for (int i = 4; i < 8; i++) begin
      #1;
      chk("pin37_drain", 32'(rf_wa), 32'(i));
      step();
    end
    chk("pin37_empty", 32'(count), 32'd0);
    // full with dequeue: no accept this cycle, accept the next
    wb_stall = 1;
    for (int i = 0; i < 4; i++) alu_put(3'(i), 32'(i));
    wb_stall = 0;
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    #1;
    chk("pin38_ardy_full", 32'(alu_ready), 32'd0);
    step();
    chk("pin38_cnt3", 32'(count), 32'd3);
    chk("pin38_ardy", 32'(alu_ready), 32'd1);
    step();
    chk("pin38_cnt_hold", 32'(count), 32'd3);
    alu_valid = 0;
    for (int i = 0; i < 4; i++) step();
    // same address twice: order kept, hazard until last dequeued
    wb_stall = 1;
    ra1 = 5;
    alu_put(5, 32'hA);
    alu_put(5, 32'hB);
    wb_stall = 0;
    #1;
    chk("pin39_wd_a", rf_wd, 32'hA);
    chk("pin39_hz_a", 32'(hz1), 32'd1);
    step();
    chk("pin39_wd_b", rf_wd, 32'hB);
    chk("pin39_hz_b", 32'(hz1), 32'd1);
    step();
    chk("pin39_hz_clr", 32'(hz1), 32'd0);
    // reset with pending writes
    wb_stall = 1;
    for (int i = 0; i < 3; i++) alu_put(3'(i + 1), 32'(i + 100));
    chk("pin40_cnt3", 32'(count), 32'd3);
    n_rst = 0;
    q.delete();
    rr = 0;
    #1;
    chk("pin40_cnt0", 32'(count), 32'd0);
    chk("pin40_we", 32'(rf_we), 32'd0);
    step();
    n_rst = 1;
    wb_stall = 0;
    for (int i = 0; i < 3; i++) step();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      alu_valid = 1'($urandom_range(0, 1));
      mem_valid = 1'($urandom_range(0, 1));
      alu_addr  = 3'($urandom);
      mem_addr  = 3'($urandom);
      alu_data  = $urandom;
      mem_data  = $urandom;
      wb_stall  = $urandom_range(0, 3) == 0;
      ra1       = 3'($urandom);
      ra2       = 3'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning write-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-005 SHALL have port alu_addr  input  3  ALU destination register.
REQ-006 SHALL have port alu_data  input  32  ALU result.
REQ-007 SHALL have port alu_ready  output  1  ALU request accepted this cycle when high together with alu_valid.
REQ-008 SHALL have port mem_valid / mem_addr / mem_data / mem_ready, with the same widths and meanings as the ALU ports, for load results.
REQ-009 SHALL have port wb_stall  input  1  hold; no register-file write this cycle.
REQ-010 SHALL have port rf_we  output  1  register-file write enable.
REQ-011 SHALL have port rf_wa  output  3  register-file write address.
REQ-012 SHALL have port rf_wd  output  32  register-file write data.
REQ-013 SHALL have port ra1, ra2  input  3 each  operand-fetch read addresses under hazard check.
REQ-014 SHALL have port hz1, hz2  output  1 each  pending write exists for ra1 / ra2.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  occupied queue entries.

Function
REQ-016 SHALL hold writes in a FIFO of DEPTH entries {addr[2:0], data[31:0]}, with registered head/tail pointers that wrap modulo DEPTH.
REQ-017 SHALL enqueue at most one request per cycle.
REQ-018 SHALL define full = (count == DEPTH); when full, alu_ready = mem_ready = 0, even if a dequeue occurs in the same cycle.
REQ-019 SHALL arbitrate with a 1-bit round-robin pointer rr (0 = ALU preferred, 1 = memory preferred).
REQ-020 SHALL drive alu_ready = !full && (!mem_valid || rr == 0) and mem_ready = !full && (!alu_valid || rr == 1), combinationally.
REQ-021 SHALL not require valid to wait for ready; ready may be high while valid is low.
REQ-022 SHALL set rr <= 1 after an accepted ALU request and rr <= 0 after an accepted memory request; rr SHALL be unchanged otherwise.
REQ-023 SHALL drive rf_we = !empty && !wb_stall, with rf_wa and rf_wd taken from the head entry; rf_wa/rf_wd SHALL be 0 when empty.
REQ-024 SHALL dequeue the head on every rising edge where rf_we = 1.
REQ-025 SHALL give a latency of exactly one cycle: a request accepted at edge k into an empty queue appears on rf_* during cycle k..k+1 and is written at edge k+1 if not stalled.
REQ-026 SHALL on simultaneous enqueue and dequeue leave count unchanged, with both pointers advancing.
REQ-027 SHALL preserve acceptance order in the write order, including repeated writes to the same address; the last accepted write wins.
REQ-028 SHALL assert hz1 combinationally when any occupied entry, head included, has addr == ra1; hz2 likewise for ra2. Requests being accepted in the current cycle are excluded.
REQ-029 SHALL treat register 0 as ordinary; there is no hardwired zero register.
REQ-030 SHALL never overwrite or drop an occupied entry, and SHALL never dequeue when empty.

Reset
REQ-031 SHALL on n_rst low asynchronously clear the pointers, count (0) and rr (0), discarding all pending writes.
REQ-032 SHALL while in reset hold rf_we = 0, rf_wa = 0, rf_wd = 0, hz1 = hz2 = 0, alu_ready = mem_ready = 0.
REQ-033 SHALL on reset asserted mid-operation with a non-empty queue produce no further rf_we pulse for the discarded entries after reset release.
REQ-034 SHALL not require the queue data storage to be reset.

Verification
REQ-035 SHALL cover: single ALU write addr=3 data=0x12345678, no stall -> rf_we=1, rf_wa=3, rf_wd=0x12345678 for exactly one cycle, starting one cycle after acceptance; count returns to 0.
REQ-036 SHALL cover: alu_valid and mem_valid held high every cycle (ALU addr=1, memory addr=2) from reset -> grants alternate ALU, memory, ALU, ...; rf_wa sequence 1,2,1,2.
REQ-037 SHALL cover: wb_stall=1 and DEPTH=4 ALU writes to addrs 4,5,6,7 -> count=4, alu_ready=0, hz1=1 for ra1=6, hz1=0 for ra1=0; wb_stall then released -> writes drain in order 4,5,6,7 over 4 cycles.
REQ-038 SHALL cover: full queue with wb_stall=0 and alu_valid=1 -> no accept that cycle, count 4->3, accept next cycle.
REQ-039 SHALL cover: two writes to addr 5 (0xA, then 0xB) -> rf_we pulses carry 0xA then 0xB; hz1 (ra1=5) stays high until the second write is dequeued.
REQ-040 SHALL cover: n_rst pulsed low with count=3 under stall -> count=0, rf_we=0, and no write pulse after release.
